// File: rtl/axis_packetizer.sv
// axis_packetizer
//   Frames an unframed AXI-S word stream by generating m_tlast. One word is
//   held back so tlast can be attached once we know whether it is the last
//   of a packet: either the programmed length is reached, or the input has
//   been idle for `timeout` cycles (flush).
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   pkt_len              words per packet (0 = 2^LSIZE), sampled at packet start
//   timeout              idle cycles before flush (0 = disabled), used live
//   s_tdata/tvalid/tready  input stream
//   m_tdata/tvalid/tlast/tready  output stream (registered)
//   pkt_cnt              packets emitted (wraps)
//   tmo_cnt              packets closed by timeout (wraps)
module axis_packetizer #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned LSIZE = 8,
    parameter int unsigned TSIZE = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [LSIZE-1:0] pkt_len,
    input  logic [TSIZE-1:0] timeout,
    input  logic [DSIZE-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [DSIZE-1:0] m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic [15:0]      pkt_cnt,
    output logic [15:0]      tmo_cnt
);

    typedef enum logic {StEmpty = 1'b0, StHold = 1'b1} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [DSIZE-1:0] r_hold_d;
    logic [LSIZE-1:0] r_idx;
    logic [LSIZE-1:0] r_len;
    logic [TSIZE-1:0] r_timer;
    logic [DSIZE-1:0] r_m_tdata;
    logic             r_m_tvalid;
    logic             r_m_tlast;
    logic [15:0]      r_pkt_cnt;
    logic [15:0]      r_tmo_cnt;

    logic             w_hold_v;
    logic             w_out_free;
    logic             w_s_fire;
    logic [LSIZE-1:0] w_len_m1;
    logic             w_final_len;
    logic             w_timer_hit;
    logic             w_move;
    logic             w_move_last;
    logic             w_restart;

    assign w_hold_v    = (r_state == StHold);
    assign w_out_free  = !r_m_tvalid | m_tready;
    assign s_tready    = !w_hold_v | w_out_free;
    assign w_s_fire    = s_tvalid & s_tready;
    // Wraps modulo 2^LSIZE, so r_len == 0 closes at idx == all-ones.
    assign w_len_m1    = r_len - LSIZE'(1);
    assign w_final_len = w_hold_v & (r_idx == w_len_m1);
    assign w_timer_hit = w_hold_v & (timeout != '0) & (r_timer == timeout);
    assign w_move      = w_hold_v & w_out_free & (w_final_len | w_s_fire | w_timer_hit);
    // A word arriving on the flush cycle keeps the packet open; length never yields.
    assign w_move_last = w_final_len | (w_timer_hit & !w_s_fire);
    // The captured word starts a new packet if nothing is held or the held one closes now.
    assign w_restart   = !w_hold_v | (w_move & w_move_last);

    assign m_tdata  = r_m_tdata;
    assign m_tvalid = r_m_tvalid;
    assign m_tlast  = r_m_tlast;
    assign pkt_cnt  = r_pkt_cnt;
    assign tmo_cnt  = r_tmo_cnt;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StEmpty: if (w_s_fire) w_state_nxt = StHold;
            StHold:  if (w_move && !w_s_fire) w_state_nxt = StEmpty;
            default: w_state_nxt = StEmpty;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Hold stage
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_hold_d <= '0;
            r_idx    <= '0;
            r_len    <= '0;
            r_timer  <= '0;
        end else if (w_s_fire) begin
            r_hold_d <= s_tdata;
            r_timer  <= '0;
            if (w_restart) begin
                r_idx <= '0;
                r_len <= pkt_len;
            end else begin
                r_idx <= r_idx + LSIZE'(1);
            end
        end else if (w_hold_v) begin
            // Saturate; also clamps if timeout is lowered below the running count.
            if (r_timer < timeout) begin
                r_timer <= r_timer + TSIZE'(1);
            end else begin
                r_timer <= timeout;
            end
        end
    end

    // Output stage
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else if (w_move) begin
            r_m_tdata  <= r_hold_d;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= w_move_last;
        end else if (m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pkt_cnt <= '0;
            r_tmo_cnt <= '0;
        end else begin
            if (r_m_tvalid && m_tready && r_m_tlast) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if (w_move && w_move_last && !w_final_len) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_packetizer.sv
// Bench for axis_packetizer: driver pushes expected words into a scoreboard,
// an independent monitor pops and compares on every output handshake.
module tb_axis_packetizer;

    localparam int DS = 8;
    localparam int LS = 8;
    localparam int TS = 16;

    typedef struct {
        logic [DS-1:0] d;
        logic          l;
        int            cap;
        int            lat;
    } exp_t;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [LS-1:0] pkt_len;
    logic [TS-1:0] timeout;
    logic [DS-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [DS-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic [15:0]   pkt_cnt;
    logic [15:0]   tmo_cnt;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   exp_pkt = 0;
    int   exp_tmo = 0;
    bit   rand_ready = 1'b0;
    bit   ready_fix = 1'b1;

    axis_packetizer #(
        .DSIZE(DS),
        .LSIZE(LS),
        .TSIZE(TS)
    ) u_dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .pkt_len (pkt_len),
        .timeout (timeout),
        .s_tdata (s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .m_tdata (m_tdata),
        .m_tvalid(m_tvalid),
        .m_tlast (m_tlast),
        .m_tready(m_tready),
        .pkt_cnt (pkt_cnt),
        .tmo_cnt (tmo_cnt)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Output-ready driver
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    // Monitor / scoreboard checker
    initial begin
        bit            stall_prev = 1'b0;
        logic [DS-1:0] pd = '0;
        logic          pl = 1'b0;
        exp_t          e;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stall_prev = 1'b0;
                continue;
            end
            if (stall_prev) begin
                check("stall_valid", m_tvalid, 1);
                check("stall_data", m_tdata, pd);
                check("stall_last", m_tlast, pl);
            end
            if (!s_tready) begin
                check("sready_low_cause", {31'd0, m_tvalid && !m_tready}, 1);
            end
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %0h want none", m_tdata);
                end else begin
                    e = sb.pop_front();
                    check("data", m_tdata, e.d);
                    check("last", m_tlast, e.l);
                    if (e.lat >= 0) check("latency", cyc - e.cap, e.lat);
                end
            end
            stall_prev = m_tvalid && !m_tready;
            pd = m_tdata;
            pl = m_tlast;
        end
    end

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(posedge aclk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL drain: got %0d words outstanding want 0", sb.size());
            sb.delete();
        end
        rand_ready = 1'b0;
        repeat (2) begin
            @(posedge aclk);
            #1;
        end
        check("pkt_cnt", pkt_cnt, exp_pkt);
        check("tmo_cnt", tmo_cnt, exp_tmo);
        check("idle_valid", m_tvalid, 0);
    endtask

    // Reference model: a word closes its packet when it is the len-th word of the
    // packet, or when the next accepted word arrives more than `tmo` idle cycles
    // later (exactly `tmo` idle cycles keeps the packet open). With m_tready
    // fixed at 1 the output latency is 1 for length closes, tmo+1 for flushes,
    // otherwise the time until the next word is accepted.
    task automatic run_phase(input int n, input logic [LS-1:0] len, input logic [TS-1:0] tmo,
                             input int gmode, input int gfix, input bit seq, input bit rnd);
        int   gaps[$];
        int   pos = 0;
        int   leff;
        int   tries;
        bit   acc;
        bit   lbl;
        bit   lbt;
        exp_t e;
        pkt_len    = len;
        timeout    = tmo;
        rand_ready = rnd;
        leff       = (len == 0) ? (1 << LS) : int'(len);
        for (int i = 0; i < n; i++) begin
            int g;
            if (i == n - 1) g = (tmo != 0) ? int'(tmo) + 8 : 0;
            else if (gmode == 0) g = gfix;
            else begin
                case ($urandom_range(0, 5))
                    0, 1:    g = 0;
                    2:       g = int'(tmo) - 1;
                    3:       g = int'(tmo);
                    4:       g = int'(tmo) + 1;
                    default: g = int'(tmo) + 3;
                endcase
            end
            gaps.push_back(g);
        end
        for (int i = 0; i < n; i++) begin
            lbl   = (pos == leff - 1);
            lbt   = (tmo != 0) && (gaps[i] > int'(tmo));
            e.d   = seq ? 8'(i) : 8'($urandom);
            e.l   = lbl || lbt;
            e.lat = rnd ? -1 : (lbl ? 1 : (lbt ? int'(tmo) + 1 : gaps[i] + 1));
            s_tdata  = e.d;
            s_tvalid = 1'b1;
            tries    = 0;
            acc      = 1'b0;
            while (!acc && tries < 1000) begin
                @(negedge aclk);
                acc = s_tready;
                @(posedge aclk);
                #1;
                tries++;
            end
            s_tvalid = 1'b0;
            if (!acc) begin
                n_total++;
                n_bad++;
                $display("FAIL accept: got no s_tready want accept of word %0d", i);
            end else begin
                e.cap = cyc;
                sb.push_back(e);
                if (e.l) exp_pkt++;
                if (lbt && !lbl) exp_tmo++;
                pos = e.l ? 0 : pos + 1;
            end
            repeat (gaps[i]) begin
                @(posedge aclk);
                #1;
            end
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        pkt_len  = 8'd4;
        timeout  = 16'd0;
        #12;
        check("rst_sready", s_tready, 1);
        check("rst_mvalid", m_tvalid, 0);
        check("rst_mlast", m_tlast, 0);
        check("rst_mdata", m_tdata, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_tmo_cnt", tmo_cnt, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        run_phase(12, 8'd4, 16'd0, 0, 0, 1'b1, 1'b0);   // 0x00..0x0B, len 4
        run_phase(3, 8'd8, 16'd5, 0, 0, 1'b0, 1'b0);    // timeout flush
        run_phase(8, 8'd8, 16'd5, 0, 0, 1'b0, 1'b0);    // next packet from idx 0
        run_phase(3, 8'd8, 16'd5, 0, 5, 1'b0, 1'b0);    // word lands on timer_hit cycle
        run_phase(512, 8'd0, 16'd0, 0, 0, 1'b0, 1'b0);  // 2^LSIZE packets
        run_phase(64, 8'd4, 16'd0, 0, 0, 1'b0, 1'b1);   // random backpressure
        for (int k = 0; k < 3; k++) begin
            run_phase(40, 8'($urandom_range(2, 6)), 16'($urandom_range(2, 6)), 1, 0, 1'b0, 1'b0);
        end

        // Reset while the output is stalled and the 2nd word is held
        pkt_len   = 8'd4;
        timeout   = 16'd0;
        ready_fix = 1'b0;
        @(posedge aclk);
        #1;
        s_tvalid = 1'b1;
        s_tdata  = 8'hA5;
        @(posedge aclk);
        #1;
        s_tdata = 8'h5A;
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        check("pre_rst_valid", m_tvalid, 1);
        check("pre_rst_data", m_tdata, 8'hA5);
        check("pre_rst_sready", s_tready, 0);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_mvalid", m_tvalid, 0);
        check("arst_mlast", m_tlast, 0);
        check("arst_mdata", m_tdata, 0);
        check("arst_sready", s_tready, 1);
        check("arst_pkt_cnt", pkt_cnt, 0);
        check("arst_tmo_cnt", tmo_cnt, 0);
        exp_pkt   = 0;
        exp_tmo   = 0;
        ready_fix = 1'b1;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        run_phase(6, 8'd3, 16'd0, 0, 0, 1'b0, 1'b0);    // fresh pkt_len after reset

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
